rect_draw_engine: RTL
=====================

// Module: rect_draw_engine
// PURPOSE
//  Parametrised fragment generator: rasterises one axis-aligned filled rectangle per request,
//  one fragment per accepted cycle, clipped to the screen. Successor to the fixed full-screen
//  fill drawer: arbitrary origin/size/colour, plot backpressure, abort. Sits between the
//  game-logic sequencer (start/finished) and the VGA adapter write port (x, y, colour, plot).
// PARAMETERS
//  X_W       8    x coordinate / width field bits
//  Y_W       7    y coordinate / height field bits
//  COLOUR_W  3    colour bits
//  SCREEN_W  160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H  120  visible rows; y >= SCREEN_H is clipped
// PORTS
//  clock       in   1         single clock, rising edge
//  reset       in   1         asynchronous, active-high
//  start       in   1         request; sampled only while finished=1
//  abort       in   1         terminate current rectangle
//  rect_x      in   X_W       origin column
//  rect_y      in   Y_W       origin row
//  rect_w      in   X_W       width in pixels (0 = empty)
//  rect_h      in   Y_W       height in pixels (0 = empty)
//  rect_colour in   COLOUR_W  fill colour
//  plot_ready  in   1         sink accepts fragment when plot&&plot_ready
//  finished    out  1         1 = idle / done, 0 = busy
//  x           out  X_W       fragment column
//  y           out  Y_W       fragment row
//  colour      out  COLOUR_W  fragment colour
//  plot        out  1         fragment valid
// BEHAVIOUR
//  - Reset (async, any state): x=0, y=0, colour=0, plot=0, finished=1, FSM=IDLE.
//  - FSM IDLE -> SETUP -> DRAW -> IDLE. All outputs registered.
//  - IDLE: finished=1, plot=0. start=1 latches rect_* inputs, finished<=0, -> SETUP. start
//    while finished=0 is ignored; inputs are don't-care outside the start cycle.
//  - SETUP (1 cycle): x_end = min(rect_x+rect_w, SCREEN_W), y_end = min(rect_y+rect_h,
//    SCREEN_H), computed in X_W+1 / Y_W+1 bits (no wrap). Empty if rect_w=0, rect_h=0,
//    rect_x>=SCREEN_W or rect_y>=SCREEN_H -> IDLE, finished<=1, no fragment emitted.
//    Else x<=rect_x, y<=rect_y, colour<=rect_colour, plot<=1, -> DRAW.
//  - Latency: start at edge N -> first plot=1 after edge N+2.
//  - DRAW: fragment held stable while plot&&!plot_ready. On accept: x+1; at x_end-1, x<=rect_x
//    and y+1 (row-major); last fragment (x_end-1, y_end-1) accepted -> plot<=0, finished<=1,
//    -> IDLE. Fragments emitted = (x_end-rect_x)*(y_end-rect_y), every one on-screen.
//  - Zero-stall throughput: one fragment per cycle; a start in the cycle finished rises is
//    accepted (back-to-back gap = 2 cycles).
//  - abort=1 in SETUP or DRAW: plot<=0, finished<=1, -> IDLE next edge; the fragment on the
//    bus that cycle is considered not accepted. abort in IDLE: no effect; abort beats start.
//  - Full-screen case (0,0,SCREEN_W,SCREEN_H) reproduces the legacy fill sequence.
// CONFIGURATION
//  RECT_DRAW_OUTLINE_EN defined: extra input outline (1 bit, latched with start). outline=1
//  -> only fragments on the unclipped rectangle's first/last row or column plot; interior
//  positions are skipped by the scan (no plot, no cycle spent). Clipped edges do not become
//  borders. outline=0 -> filled.
//  Not defined: port absent, always filled.
// STRUCTURE
//  draw_pkg: X_W, Y_W, COLOUR_W, SCREEN_W, SCREEN_H defaults, colour constants (BLACK=3'b000,
//  GREEN=3'b010, ...), FSM state encoding. Sub-module draw_clip: combinational clip / empty
//  calculation (x_end, y_end, empty) used by SETUP; instantiated once.
// TESTING
//  1 rect (10,20,3,2,GREEN), plot_ready=1 -> 6 fragments (10..12,20),(10..12,21), first
//    plot 2 cycles after start, finished=1 the cycle after (12,21).
//  2 rect (158,118,5,5), plot_ready=1 -> 4 fragments (158..159,118..119), nothing off-screen.
//  3 rect_w=0, and rect_x=170 -> zero plots, finished back to 1 two cycles after start.
//  4 rect (0,0,2,2), plot_ready toggled 1,0,0,1,... -> x/y/colour stable while stalled, 4
//    fragments in order, none duplicated or lost.
//  5 abort after 3rd accepted fragment of (0,0,4,4) -> plot=0, finished=1 next edge; new
//    start then behaves as in 1. Async reset mid-DRAW -> all outputs at reset values at once.
//  6 (OUTLINE_EN) rect (5,5,4,3) outline=1 -> 10 fragments, (6,6),(7,6) absent.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared defaults, colour constants and FSM encoding for the rectangle draw engine.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } draw_state_e;

endpackage

// File: rtl/draw_clip.sv
// Combinational clip of a rectangle against the screen: exclusive end column/row and empty flag.
module draw_clip #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic [X_W-1:0] rect_x_i,
    input  logic [Y_W-1:0] rect_y_i,
    input  logic [X_W-1:0] rect_w_i,
    input  logic [Y_W-1:0] rect_h_i,
    output logic [X_W:0]   x_end_o,
    output logic [Y_W:0]   y_end_o,
    output logic           empty_o
);

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    // One extra bit on the sums so origin+size never wraps before the clip.
    always_comb begin
        x_sum   = {1'b0, rect_x_i} + {1'b0, rect_w_i};
        y_sum   = {1'b0, rect_y_i} + {1'b0, rect_h_i};
        x_end_o = (x_sum > SCR_W) ? SCR_W : x_sum;
        y_end_o = (y_sum > SCR_H) ? SCR_H : y_sum;
        empty_o = (rect_w_i == '0) || (rect_h_i == '0) ||
                  ({1'b0, rect_x_i} >= SCR_W) || ({1'b0, rect_y_i} >= SCR_H);
    end

endmodule

// File: rtl/rect_draw_engine.sv
// Rasterises one clipped, axis-aligned filled rectangle per start, one fragment per accept.
// Optional RECT_DRAW_OUTLINE_EN adds an outline input that restricts output to the border.
module rect_draw_engine
    import draw_pkg::*;
#(
    parameter int X_W      = draw_pkg::X_W,
    parameter int Y_W      = draw_pkg::Y_W,
    parameter int COLOUR_W = draw_pkg::COLOUR_W,
    parameter int SCREEN_W = draw_pkg::SCREEN_W,
    parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [X_W-1:0]      rect_x,
    input  logic [Y_W-1:0]      rect_y,
    input  logic [X_W-1:0]      rect_w,
    input  logic [Y_W-1:0]      rect_h,
    input  logic [COLOUR_W-1:0] rect_colour,
`ifdef RECT_DRAW_OUTLINE_EN
    input  logic                outline,
`endif
    input  logic                plot_ready,
    output logic                finished,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output draw_state_e         state_dbg
);

    // Handshake: a fragment transfers on a rising edge where plot && plot_ready && !abort;
    // while plot && !plot_ready the x/y/colour outputs do not change.

    draw_state_e         state_q;
    logic [X_W-1:0]      x_q, rx_q, rw_q;
    logic [Y_W-1:0]      y_q, ry_q, rh_q;
    logic [COLOUR_W-1:0] colour_q, col_q;
    logic                plot_q, fin_q, outl_q;
    logic [X_W:0]        xe_q;
    logic [Y_W:0]        ye_q;

    logic                outline_in;
    logic [X_W:0]        clip_xe;
    logic [Y_W:0]        clip_ye;
    logic                clip_empty;

    logic [X_W:0]        x_inc, x_far, x_cand;
    logic [Y_W:0]        y_inc, y_far;
    logic                border_row, wrap_d, last_d;
    logic [X_W-1:0]      nx_d;
    logic [Y_W-1:0]      ny_d;

`ifdef RECT_DRAW_OUTLINE_EN
    assign outline_in = outline;
`else
    assign outline_in = 1'b0;
`endif

    draw_clip #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .rect_x_i (rx_q),
        .rect_y_i (ry_q),
        .rect_w_i (rw_q),
        .rect_h_i (rh_q),
        .x_end_o  (clip_xe),
        .y_end_o  (clip_ye),
        .empty_o  (clip_empty)
    );

    // Next scan position. Interior rows of an outline jump from the left edge straight to the
    // unclipped right edge, and wrap if that edge is off-screen.
    always_comb begin
        x_inc      = {1'b0, x_q} + (X_W+1)'(1);
        x_far      = {1'b0, rx_q} + {1'b0, rw_q} - (X_W+1)'(1);
        y_inc      = {1'b0, y_q} + (Y_W+1)'(1);
        y_far      = {1'b0, ry_q} + {1'b0, rh_q} - (Y_W+1)'(1);
        border_row = !outl_q || (y_q == ry_q) || ({1'b0, y_q} == y_far);
        if (border_row) begin
            x_cand = x_inc;
        end else if (x_q == rx_q) begin
            x_cand = x_far;
        end else begin
            x_cand = xe_q;
        end
        wrap_d = (x_cand >= xe_q) || (x_cand <= {1'b0, x_q});
        last_d = wrap_d && (y_inc >= ye_q);
        nx_d   = wrap_d ? rx_q : x_cand[X_W-1:0];
        ny_d   = wrap_d ? y_inc[Y_W-1:0] : y_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            fin_q    <= 1'b1;
            rx_q     <= '0;
            ry_q     <= '0;
            rw_q     <= '0;
            rh_q     <= '0;
            col_q    <= '0;
            outl_q   <= 1'b0;
            xe_q     <= '0;
            ye_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    fin_q  <= 1'b1;
                    if (start && !abort) begin
                        rx_q    <= rect_x;
                        ry_q    <= rect_y;
                        rw_q    <= rect_w;
                        rh_q    <= rect_h;
                        col_q   <= rect_colour;
                        outl_q  <= outline_in;
                        fin_q   <= 1'b0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (abort || clip_empty) begin
                        fin_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        x_q      <= rx_q;
                        y_q      <= ry_q;
                        colour_q <= col_q;
                        xe_q     <= clip_xe;
                        ye_q     <= clip_ye;
                        plot_q   <= 1'b1;
                        state_q  <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (abort || (plot_ready && last_d)) begin
                        plot_q  <= 1'b0;
                        fin_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (plot_ready) begin
                        x_q <= nx_d;
                        y_q <= ny_d;
                    end
                end
                default: begin
                    plot_q  <= 1'b0;
                    fin_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign finished  = fin_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign state_dbg = state_q;

endmodule
